// File: rtl/axi_write_slave.sv
// Single-beat AXI4 write responder in front of the data RAM model.
// Latency: handshake edge E -> mem_wen during cycle after E+LATENCY -> BVALID at E+LATENCY+1.
// Backpressure: one transaction in flight; AWREADY/WREADY stay low until B is accepted.
module axi_write_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0800_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WLAST,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  output logic        mem_wen,
  output logic [28:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // WAIT lasts LATENCY cycles: load LATENCY-1 and leave when the count hits zero.
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state;
  logic        aw_got;
  logic        w_got;
  logic [31:0] addr_q;
  logic [63:0] data_q;
  logic [7:0]  strb_q;
  logic        last_q;
  logic [3:0]  cnt;
  logic [1:0]  resp_q;

  logic        aw_hs;
  logic        w_hs;
  logic        both_captured;
  logic [31:0] addr_n;
  logic [63:0] data_n;
  logic [7:0]  strb_n;
  logic        last_n;
  logic        in_range;
  logic [1:0]  resp_n;
  logic        go_write;

  // Next-latch view so a zero-latency transaction can write on its handshake edge.
  always_comb begin
    aw_hs         = AWVALID & AWREADY;
    w_hs          = WVALID & WREADY;
    both_captured = (aw_got | aw_hs) & (w_got | w_hs);
    addr_n        = aw_hs ? AWADDR : addr_q;
    data_n        = w_hs ? WDATA : data_q;
    strb_n        = w_hs ? WSTRB : strb_q;
    last_n        = w_hs ? WLAST : last_q;
    // Subtract first so a range touching the top of the address space cannot overflow.
    in_range      = (addr_n >= ADDR_BASE) && ((addr_n - ADDR_BASE) < ADDR_SIZE);
    if (!in_range) begin
      resp_n = RESP_DECERR;
    end else if (!last_n) begin
      resp_n = RESP_SLVERR;
    end else begin
      resp_n = RESP_OKAY;
    end
    go_write = ((state == IDLE) && both_captured && (LATENCY == 0)) ||
               ((state == WAIT) && (cnt == 4'd0));
  end

  // Transaction FSM with all AXI and memory outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      last_q    <= 1'b0;
      cnt       <= '0;
      resp_q    <= RESP_OKAY;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q <= AWADDR;
          end
          if (w_hs) begin
            data_q <= WDATA;
            strb_q <= WSTRB;
            last_q <= WLAST;
          end
          if (both_captured) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end
          end else begin
            // Also raises both readies on the first edge out of reset.
            aw_got  <= aw_got | aw_hs;
            w_got   <= w_got | w_hs;
            AWREADY <= ~(aw_got | aw_hs);
            WREADY  <= ~(w_got | w_hs);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE: begin
          state  <= RESP;
          BVALID <= 1'b1;
          BRESP  <= resp_q;
        end
        RESP: begin
          if (BREADY) begin
            state   <= IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Single-cycle memory write; error responses and empty strobes suppress the enable.
      if (go_write) begin
        state     <= WRITE;
        resp_q    <= resp_n;
        mem_wen   <= (resp_n == RESP_OKAY) && (strb_n != 8'h00);
        mem_waddr <= addr_n[31:3];
        mem_wdata <= data_n;
        mem_wmask <= strb_n;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_slave.sv
// Self-checking bench for axi_write_slave (LATENCY=2).
// Scoreboard queues hold expected memory writes and B responses; a monitor pops them.
// Inline cycle-accurate checks cover timing, backpressure and reset behaviour.
module tb_axi_write_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic        WVALID;
  logic        WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        mem_wen;
  logic [28:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } mw_t;

  mw_t        mem_q[$];
  logic [1:0] b_q[$];
  mw_t        em;
  logic [1:0] eb;
  int         tests = 0;
  int         fails = 0;

  axi_write_slave #(
    .ADDR_BASE(32'h8000_0000),
    .ADDR_SIZE(32'h0800_0000),
    .LATENCY  (2)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .mem_wen  (mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic l);
    if (a < 32'h8000_0000 || a > 32'h87FF_FFFF) return 2'b11;
    if (!l) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge ACLK);
      if (!ARESET && mem_wen) begin
        tests++;
        if (mem_q.size() == 0) begin
          fails++;
          $display("FAIL mem_write_unexpected: got addr=%h mask=%h, required no write", mem_waddr, mem_wmask);
        end else begin
          em = mem_q.pop_front();
          if ({mem_waddr, mem_wdata, mem_wmask} !== em) begin
            fails++;
            $display("FAIL mem_write: got %h/%h/%h, required %h/%h/%h",
                     mem_waddr, mem_wdata, mem_wmask, em.a, em.d, em.m);
          end
        end
      end
      if (!ARESET && BVALID && BREADY) begin
        tests++;
        if (b_q.size() == 0) begin
          fails++;
          $display("FAIL bresp_unexpected: got %b, required no response", BRESP);
        end else begin
          eb = b_q.pop_front();
          if (BRESP !== eb) begin
            fails++;
            $display("FAIL bresp: got %b, required %b", BRESP, eb);
          end
        end
      end
    end
  endtask

  task automatic wait_bvalid(input string name);
    int n;
    n = 0;
    while (!BVALID && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (!BVALID) begin
      fails++;
      $display("FAIL %s_timeout: BVALID=%b after %0d cycles, required 1", name, BVALID, n);
    end
  endtask

  task automatic do_txn(input string name, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic l);
    logic [1:0] r;
    r = exp_resp(a, l);
    b_q.push_back(r);
    if (r == 2'b00 && s != 8'h00) mem_q.push_back(mw_t'({a[31:3], d, s}));
    AWVALID = 1'b1; AWADDR = a; WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = l;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_bvalid(name);
    tests++;
    if (BRESP !== r) begin
      fails++;
      $display("FAIL %s_bresp: got %b, required %b", name, BRESP, r);
    end
    step();
    tests++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      fails++;
      $display("FAIL %s_done: got bvalid/awready/wready=%b, required 011", name, {BVALID, AWREADY, WREADY});
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    #2;
    tests++;
    if ({AWREADY, WREADY, BVALID, BRESP, mem_wen} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 000000", {AWREADY, WREADY, BVALID, BRESP, mem_wen});
    end
    tests++;
    if ({mem_waddr, mem_wdata, mem_wmask} !== 101'b0) begin
      fails++;
      $display("FAIL reset_mem: got %h/%h/%h, required 0", mem_waddr, mem_wdata, mem_wmask);
    end
    step();
    step();
    ARESET = 1'b0;
    #1;
    tests++;
    if ({AWREADY, WREADY} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready_early: got %b, required 00", {AWREADY, WREADY});
    end
    step();
    tests++;
    if ({AWREADY, WREADY} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 11", {AWREADY, WREADY});
    end
  endtask

  task automatic test_same_edge();
    b_q.push_back(2'b00);
    mem_q.push_back(mw_t'({29'h1000_0002, 64'h1122_3344_5566_7788, 8'hFF}));
    AWVALID = 1'b1; AWADDR = 32'h8000_0010; WVALID = 1'b1;
    WDATA = 64'h1122_3344_5566_7788; WSTRB = 8'hFF; WLAST = 1'b1; BREADY = 1'b1;
    step();  // E
    AWVALID = 1'b0; WVALID = 1'b0;
    tests++;
    if ({AWREADY, WREADY} !== 2'b00) begin
      fails++;
      $display("FAIL same_edge_ready: got %b, required 00", {AWREADY, WREADY});
    end
    step();  // E+1
    tests++;
    if (mem_wen !== 1'b0) begin
      fails++;
      $display("FAIL same_edge_early_wen: got %b, required 0", mem_wen);
    end
    step();  // E+2
    tests++;
    if ({mem_wen, mem_waddr, mem_wmask} !== {1'b1, 29'h1000_0002, 8'hFF}) begin
      fails++;
      $display("FAIL same_edge_wen: got %b/%h/%h, required 1/10000002/ff", mem_wen, mem_waddr, mem_wmask);
    end
    step();  // E+3
    tests++;
    if ({mem_wen, BVALID, BRESP} !== 4'b0100) begin
      fails++;
      $display("FAIL same_edge_b: got wen/bvalid/bresp=%b, required 0100", {mem_wen, BVALID, BRESP});
    end
    step();  // E+4
    tests++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      fails++;
      $display("FAIL same_edge_done: got %b, required 011", {BVALID, AWREADY, WREADY});
    end
  endtask

  task automatic test_w_first();
    b_q.push_back(2'b00);
    mem_q.push_back(mw_t'({29'h1000_0001, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F}));
    WVALID = 1'b1; WDATA = 64'hCAFE_F00D_DEAD_BEEF; WSTRB = 8'h0F; WLAST = 1'b1;
    step();  // E
    WVALID = 1'b0;
    tests++;
    if ({AWREADY, WREADY} !== 2'b10) begin
      fails++;
      $display("FAIL w_first_ready: got %b, required 10", {AWREADY, WREADY});
    end
    step();
    step();  // E+2
    AWVALID = 1'b1; AWADDR = 32'h8000_0008;
    step();  // E+3
    AWVALID = 1'b0;
    tests++;
    if ({AWREADY, WREADY, mem_wen} !== 3'b000) begin
      fails++;
      $display("FAIL w_first_aw: got %b, required 000", {AWREADY, WREADY, mem_wen});
    end
    step();  // E+4
    tests++;
    if (mem_wen !== 1'b0) begin
      fails++;
      $display("FAIL w_first_early_wen: got %b, required 0", mem_wen);
    end
    step();  // E+5
    tests++;
    if ({mem_wen, mem_wmask} !== {1'b1, 8'h0F}) begin
      fails++;
      $display("FAIL w_first_wen: got %b/%h, required 1/0f", mem_wen, mem_wmask);
    end
    step();  // E+6
    tests++;
    if ({BVALID, BRESP} !== 3'b100) begin
      fails++;
      $display("FAIL w_first_b: got %b, required 100", {BVALID, BRESP});
    end
    step();
  endtask

  task automatic test_errors();
    do_txn("decerr_low", 32'h1000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    do_txn("slverr", 32'h8000_0100, 64'h5555_AAAA_5555_AAAA, 8'hFF, 1'b0);
    do_txn("last_in_range", 32'h87FF_FFF8, 64'h0F0F_0F0F_F0F0_F0F0, 8'h81, 1'b1);
    do_txn("first_out_range", 32'h8800_0000, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    do_txn("below_base", 32'h7FFF_FFF8, 64'h9999_8888_7777_6666, 8'hFF, 1'b1);
    do_txn("base_unaligned", 32'h8000_0005, 64'hA5A5_5A5A_A5A5_5A5A, 8'h3C, 1'b1);
    do_txn("zero_strb", 32'h8000_0040, 64'hDEAD_0000_BEEF_0000, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    b_q.push_back(2'b00);
    mem_q.push_back(mw_t'({29'h1000_0020, 64'h7766_5544_3322_1100, 8'hF0}));
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h8000_0100; WVALID = 1'b1;
    WDATA = 64'h7766_5544_3322_1100; WSTRB = 8'hF0; WLAST = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_bvalid("backpressure");
    for (int i = 0; i < 5; i++) begin
      // Valids toggle while readies are low; none of this may be captured.
      AWVALID = i[0]; AWADDR = 32'h8000_0200; WVALID = ~i[0]; WDATA = '1; WSTRB = 8'hFF;
      step();
      tests++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
        fails++;
        $display("FAIL backpressure_hold%0d: got %b, required 10000", i, {BVALID, BRESP, AWREADY, WREADY});
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    step();
    tests++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      fails++;
      $display("FAIL backpressure_release: got %b, required 011", {BVALID, AWREADY, WREADY});
    end
  endtask

  task automatic test_reset_wait();
    AWVALID = 1'b1; AWADDR = 32'h8000_0300; WVALID = 1'b1;
    WDATA = 64'hFFFF_0000_FFFF_0000; WSTRB = 8'hFF; WLAST = 1'b1;
    step();  // E
    AWVALID = 1'b0; WVALID = 1'b0;
    step();  // E+1, still in WAIT
    ARESET = 1'b1;
    #1;
    tests++;
    if ({AWREADY, WREADY, BVALID, BRESP, mem_wen} !== 6'b0 ||
        {mem_waddr, mem_wdata, mem_wmask} !== 101'b0) begin
      fails++;
      $display("FAIL reset_wait_outputs: got %b %h/%h/%h, required all 0",
               {AWREADY, WREADY, BVALID, BRESP, mem_wen}, mem_waddr, mem_wdata, mem_wmask);
    end
    step();
    step();
    ARESET = 1'b0;
    step();
    tests++;
    if ({AWREADY, WREADY, BVALID, mem_wen} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_wait_ready: got %b, required 1100", {AWREADY, WREADY, BVALID, mem_wen});
    end
    step();
    tests++;
    if (mem_wen !== 1'b0) begin
      fails++;
      $display("FAIL reset_wait_no_wen: got %b, required 0", mem_wen);
    end
    do_txn("after_reset", 32'h8000_0400, 64'h0BAD_CAFE_1234_5678, 8'hA5, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_txn("b2b", 32'h8000_1000 + 32'(i * 8), {32'(i), 32'hC0DE_0000 + 32'(i)},
             8'(8'h11 << i), 1'b1);
    end
  endtask

  initial begin
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    BREADY = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_same_edge();
    test_w_first();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_back_to_back();
    step();
    step();
    tests++;
    if (mem_q.size() != 0 || b_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes and %0d responses left, required 0 and 0",
               mem_q.size(), b_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- Memory-side responder for the single-beat AXI4 write channel issued by the core's store unit.
- Accepts one AW beat and one W beat in either order or in the same cycle, then waits a configurable number of cycles to model memory latency.
- Issues exactly one registered write to the backing data memory port, then returns a B response.
- One transaction outstanding at a time; sits between the LSU write master and the data RAM model.

Parameters:
- ADDR_BASE, 32'h8000_0000, first byte address decoded as memory.
- ADDR_SIZE, 32'h0800_0000, bytes of decoded memory; range is [ADDR_BASE, ADDR_BASE+ADDR_SIZE).
- LATENCY, 2, cycles spent in WAIT before the memory write (0..15 legal).

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  32  byte address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  64  write data.
- WSTRB  in  8  byte strobes.
- WLAST  in  1  last beat; must be 1 for every beat.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- mem_wen  out  1  one-cycle memory write enable.
- mem_waddr  out  29  doubleword index, AWADDR[31:3].
- mem_wdata  out  64  captured WDATA.
- mem_wmask  out  8  captured WSTRB.

Behaviour:
- Reset (asynchronous, takes effect immediately on ARESET=1): state=IDLE; AWREADY=0, WREADY=0, BVALID=0, BRESP=00, mem_wen=0, mem_waddr=0, mem_wdata=0, mem_wmask=0. Capture flags and latency counter clear. Any in-flight transaction is dropped with no memory write and no response.
- First rising edge after ARESET deasserts: AWREADY=1, WREADY=1.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - AW handshake (AWVALID&AWREADY at an edge): latch AWADDR; AWREADY=0 from that edge.
  - W handshake: latch WDATA, WSTRB, WLAST; WREADY=0 from that edge.
  - Both handshakes may complete at the same edge, or in either order across any number of cycles.
  - On the edge at which both are captured: go to WAIT if LATENCY>0, otherwise go to WRITE.
- Response decision, computed from the latched values:
  - DECERR if the address is outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE).
  - Otherwise SLVERR if WLAST=0.
  - Otherwise OKAY.
- WAIT: 4-bit down-counter loaded with LATENCY-1; stay exactly LATENCY cycles, then go to WRITE.
- WRITE (one cycle):
  - mem_wen=1 only if response is OKAY and WSTRB!=0.
  - mem_waddr/mem_wdata/mem_wmask driven from the latches.
  - Address bits [2:0] are ignored. No data realignment.
  - Next state RESP.
- Timing: mem_wen is high during the cycle following edge E+LATENCY, where E is the completing handshake edge. BVALID rises at edge E+LATENCY+1.
- RESP:
  - BVALID=1; BRESP holds stable until BREADY=1 at an edge.
  - On that edge: BVALID=0, AWREADY=1, WREADY=1, state=IDLE.
  - Back-to-back transaction gap: at least one cycle of ready after the response.
- AWVALID/WVALID toggling while ready is low is ignored. There is no second capture before B completes.
- mem_wen is never high outside WRITE. It is high for at most one cycle per transaction.

Test Plan:
- LATENCY=2; AW and W same edge E, AWADDR=32'h8000_0010, WDATA=64'h1122_3344_5566_7788, WSTRB=8'hFF, BREADY held 1 -> mem_wen high during the one cycle after E+2 with mem_waddr=29'h1000_0002, mem_wmask=8'hFF; BVALID=1, BRESP=00 from E+3, clears at E+4.
- W at edge E, AW 3 cycles later (AWADDR=32'h8000_0008, WSTRB=8'h0F) -> WREADY low from E, AWREADY low from E+3; mem_wen after E+5 with mem_wmask=8'h0F; OKAY response.
- AWADDR=32'h1000_0000 -> no mem_wen pulse; BRESP=11.
- WLAST=0 at an in-range address -> no mem_wen pulse; BRESP=10.
- BREADY held 0 for 5 cycles after BVALID -> BVALID/BRESP stable and AWREADY/WREADY stay 0; release -> both readies=1 on the following edge.
- ARESET asserted during WAIT -> all outputs 0 immediately; no mem_wen pulse; readies=1 on first edge after release; a new transaction completes normally.
